// File: rtl/store_dec.sv
// store_dec: loadable store drained by STEP per accepted request, falling-edge FSM.
// Optional macro STORE_DEC_SATURATE_EN: accept a partial final decrement down to zero.
`default_nettype none

module store_dec #(
  parameter int WIDTH = 32,
  parameter int STEP  = 3,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             dec_req,
  output logic             dec_ack,
  output logic [WIDTH-1:0] store,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             underflow,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    EMPTY  = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] STEP_V = WIDTH'(STEP);

  state_t           state;
  logic [WIDTH-1:0] store_less_step;
  logic [CNT_W-1:0] count_inc;

  assign store_less_step = store - STEP_V;
  assign count_inc       = (&count) ? count : count + 1'b1;

  always_ff @(negedge clock or posedge clear) begin
    if (clear) begin
      state     <= IDLE;
      store     <= '0;
      count     <= '0;
      dec_ack   <= 1'b0;
      underflow <= 1'b0;
    end else begin
      dec_ack <= 1'b0;
      if (load) begin
        // A request on the load edge is dropped outright.
        store     <= load_value;
        count     <= '0;
        underflow <= 1'b0;
        state     <= (load_value >= STEP_V) ? ACTIVE : EMPTY;
      end else begin
        case (state)
          IDLE: ;
          ACTIVE: begin
            if (dec_req) begin
              store   <= store_less_step;
              count   <= count_inc;
              dec_ack <= 1'b1;
              if (store_less_step < STEP_V) state <= EMPTY;
            end
          end
          EMPTY: begin
            if (dec_req) begin
`ifdef STORE_DEC_SATURATE_EN
              if (store != '0) begin
                store   <= '0;
                count   <= count_inc;
                dec_ack <= 1'b1;
              end else begin
                underflow <= 1'b1;
              end
`else
              underflow <= 1'b1;
`endif
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign empty = (store < STEP_V);
  assign busy  = (state == ACTIVE);

endmodule

`default_nettype wire

// File: tb/tb_store_dec.sv
// Self-checking bench for store_dec (STEP=3, WIDTH=32, CNT_W=4 to reach count saturation).
`default_nettype none

module tb_store_dec;

  localparam int WIDTH = 32;
  localparam int STEP  = 3;
  localparam int CNT_W = 4;

  logic             clock = 1'b0;
  logic             clear;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic             dec_req;
  logic             dec_ack;
  logic [WIDTH-1:0] store;
  logic [CNT_W-1:0] count;
  logic             empty;
  logic             underflow;
  logic             busy;

  store_dec #(.WIDTH(WIDTH), .STEP(STEP), .CNT_W(CNT_W)) dut (
    .clock      (clock),
    .clear      (clear),
    .load       (load),
    .load_value (load_value),
    .dec_req    (dec_req),
    .dec_ack    (dec_ack),
    .store      (store),
    .count      (count),
    .empty      (empty),
    .underflow  (underflow),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [WIDTH-1:0] st;
    logic [CNT_W-1:0] cnt;
    logic             ack;
    logic             emp;
    logic             bsy;
    logic             uf;
  } exp_t;

  exp_t sb[$];
  int   passed = 0;
  int   total  = 0;

  function automatic exp_t mk(input int st, input int cnt, input bit ack,
                              input bit emp, input bit bsy, input bit uf);
    exp_t e;
    e.st  = WIDTH'(st);
    e.cnt = CNT_W'(cnt);
    e.ack = ack;
    e.emp = emp;
    e.bsy = bsy;
    e.uf  = uf;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    total++;
    assert (act === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic compare(input string step_name);
    exp_t e;
    total++;
    assert (sb.size() > 0) begin
      passed++;
    end else begin
      $error("FAIL %s scoreboard: got 0 entries expected 1", step_name);
      return;
    end
    e = sb.pop_front();
    chk({step_name, ".store"},     store,            e.st);
    chk({step_name, ".count"},     WIDTH'(count),    WIDTH'(e.cnt));
    chk({step_name, ".dec_ack"},   WIDTH'(dec_ack),  WIDTH'(e.ack));
    chk({step_name, ".empty"},     WIDTH'(empty),    WIDTH'(e.emp));
    chk({step_name, ".busy"},      WIDTH'(busy),     WIDTH'(e.bsy));
    chk({step_name, ".underflow"}, WIDTH'(underflow), WIDTH'(e.uf));
  endtask

  // Inputs change on the rising edge, DUT samples on the falling edge,
  // outputs are checked on the following rising edge.
  task automatic step(input string name, input bit ld, input int val, input bit req, input exp_t e);
    load       = ld;
    load_value = WIDTH'(val);
    dec_req    = req;
    sb.push_back(e);
    @(negedge clock);
    @(posedge clock);
    compare(name);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    clear      = 1'b1;
    load       = 1'b0;
    load_value = '0;
    dec_req    = 1'b0;
    #12;
    clear = 1'b0;
    sb.push_back(mk(0, 0, 0, 1, 0, 0));
    compare("reset");
    @(posedge clock);

    step("idle_req", 0, 0, 1, mk(0, 0, 0, 1, 0, 0));
    step("load10",   1, 10, 0, mk(10, 0, 0, 0, 1, 0));
    step("dec1",     0, 0, 1, mk(7, 1, 1, 0, 1, 0));
    step("dec2",     0, 0, 1, mk(4, 2, 1, 0, 1, 0));
    step("dec3",     0, 0, 1, mk(1, 3, 1, 1, 0, 0));
`ifdef STORE_DEC_SATURATE_EN
    step("dec4",     0, 0, 1, mk(0, 4, 1, 1, 0, 0));
    step("hold",     0, 0, 0, mk(0, 4, 0, 1, 0, 0));
`else
    step("dec4",     0, 0, 1, mk(1, 3, 0, 1, 0, 1));
    step("hold",     0, 0, 0, mk(1, 3, 0, 1, 0, 1));
`endif

    step("load2",    1, 2, 0, mk(2, 0, 0, 1, 0, 0));
`ifdef STORE_DEC_SATURATE_EN
    step("load2_req",  0, 0, 1, mk(0, 1, 1, 1, 0, 0));
    step("load2_req2", 0, 0, 1, mk(0, 1, 0, 1, 0, 1));
`else
    step("load2_req",  0, 0, 1, mk(2, 0, 0, 1, 0, 1));
    step("load2_req2", 0, 0, 1, mk(2, 0, 0, 1, 0, 1));
`endif

    step("load9_req", 1, 9, 1, mk(9, 0, 0, 0, 1, 0));
    step("after9",    0, 0, 1, mk(6, 1, 1, 0, 1, 0));
    step("idle9",     0, 0, 0, mk(6, 1, 0, 0, 1, 0));

    // Drain long enough to exercise counter saturation at all-ones.
    step("load100", 1, 100, 0, mk(100, 0, 0, 0, 1, 0));
    for (int k = 1; k <= 17; k++) begin
      int exp_st;
      int exp_cnt;
      exp_st  = 100 - STEP * k;
      exp_cnt = (k > 15) ? 15 : k;
      step($sformatf("sat%0d", k), 0, 0, 1, mk(exp_st, exp_cnt, 1, 0, 1, 0));
    end

    step("reload5",  1, 5, 1, mk(5, 0, 0, 0, 1, 0));
    step("dec5",     0, 0, 1, mk(2, 1, 1, 1, 0, 0));

    step("load30",   1, 30, 0, mk(30, 0, 0, 0, 1, 0));
    step("dec30a",   0, 0, 1, mk(27, 1, 1, 0, 1, 0));
    step("dec30b",   0, 0, 1, mk(24, 2, 1, 0, 1, 0));
    #2;
    clear = 1'b1;
    #1;
    sb.push_back(mk(0, 0, 0, 1, 0, 0));
    compare("clear_mid");
    @(negedge clock);
    #1;
    sb.push_back(mk(0, 0, 0, 1, 0, 0));
    compare("clear_held");
    clear   = 1'b0;
    dec_req = 1'b0;
    @(posedge clock);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
